// File: rtl/pkt_counter_bank_if.sv
// pkt_counter_bank_if: AXI4-Lite control bus bundle for pkt_counter_bank.
// Signals: aw* write address, w* write data, b* write response,
//          ar* read address, r* read data; all 32-bit data, AW-bit byte address.
// Modports: slave (the counter bank), master (the interconnect / bench side).
interface pkt_counter_bank_if #(
    parameter int AW = 8
);
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [2:0]    awprot;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [2:0]    arprot;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    modport slave (
        input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, arprot, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, arprot, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/pkt_counter_bank.sv
// pkt_counter_bank: NCH packet counters with snapshot bank, clear, sticky overflow and AXI4-Lite slave.
// Ports: clk     - clock, rising edge
//        resetn  - asynchronous active-low reset
//        pkt_inc - per-channel one-cycle increment strobes
//        s_axi   - AXI4-Lite slave (ID, CTRL, OVF, SNAP_HI/LO[i] registers)
module pkt_counter_bank #(
    parameter int NCH = 8,
    parameter int CW  = 48,
    parameter int SAT = 1,
    parameter int AW  = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [NCH-1:0]   pkt_inc,
    pkt_counter_bank_if.slave s_axi
);
    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_ACCEPT = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;
    localparam logic [0:0] R_IDLE   = 1'b0;
    localparam logic [0:0] R_RESP   = 1'b1;
    // highest word index that belongs to the register map
    localparam int LAST = 3 + 2 * NCH;

    if (NCH < 1 || NCH > 30 || LAST >= 2 ** (AW - 2) || CW < 1 || CW > 64) begin : g_bad_cfg
        $error("pkt_counter_bank: unsupported NCH/CW/AW combination");
    end

    logic [1:0]    r_wstate;
    logic [1:0]    r_bresp;
    logic [0:0]    r_rstate;
    logic          r_arready;
    logic [31:0]   r_rdata;
    logic [1:0]    r_rresp;
    logic [CW-1:0] r_cnt  [NCH];
    logic [CW-1:0] r_snap [NCH];
    logic [NCH-1:0] r_ovf;

    logic [31:0]    w_widx;
    logic [31:0]    w_ridx;
    logic           w_wr;
    logic           w_snap;
    logic           w_clr;
    logic [NCH-1:0] w_w1c;
    logic [NCH-1:0] w_ovf_ev;
    logic [1:0]     w_bresp;
    logic [31:0]    w_rdata;
    logic [1:0]     w_rresp;
    logic           w_unused;

    assign w_widx  = 32'(s_axi.awaddr[AW-1:2]);
    assign w_ridx  = 32'(s_axi.araddr[AW-1:2]);
    // register actions fire only in the single accept cycle
    assign w_wr    = r_wstate == W_ACCEPT;
    assign w_snap  = w_wr && w_widx == 1 && s_axi.wdata[0];
    assign w_clr   = w_wr && w_widx == 1 && s_axi.wdata[1];
    assign w_w1c   = (w_wr && w_widx == 2) ? s_axi.wdata[NCH-1:0] : '0;
    assign w_bresp = (w_widx == 1 || w_widx == 2) ? 2'd0 : w_widx <= LAST ? 2'd2 : 2'd3;
    assign w_unused = &{1'b0, s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.awprot,
                        s_axi.arprot, s_axi.wstrb, s_axi.wdata};

    // an increment lost to a same-cycle clear is not an overflow
    always_comb begin
        w_ovf_ev = '0;
        for (int i = 0; i < NCH; i++) w_ovf_ev[i] = pkt_inc[i] && (&r_cnt[i]) && !w_clr;
    end

    always_comb begin
        w_rdata = '0;
        w_rresp = 2'd0;
        if (w_ridx == 0) w_rdata = {16'h5043, 8'(CW), 8'(NCH)};
        else if (w_ridx == 2) w_rdata = 32'(r_ovf);
        else if (w_ridx > LAST) w_rresp = 2'd3;
        for (int i = 0; i < NCH; i++) begin
            if (w_ridx == 4 + 2 * i) w_rdata = 32'(64'(r_snap[i]) >> 32);
            if (w_ridx == 5 + 2 * i) w_rdata = 32'(r_snap[i]);
        end
    end

    // snapshot takes the pre-increment, pre-clear value, giving atomic read-and-clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i]  <= '0;
                r_snap[i] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_snap) r_snap[i] <= r_cnt[i];
                r_cnt[i] <= w_clr ? '0 : !pkt_inc[i] ? r_cnt[i] : !(&r_cnt[i]) ? r_cnt[i] + 1'b1 :
                            SAT != 0 ? r_cnt[i] : '0;
            end
            r_ovf <= w_ovf_ev | (r_ovf & ~w_w1c);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wstate <= W_IDLE;
            r_bresp  <= 2'd0;
        end else begin
            r_wstate <= r_wstate == W_IDLE ? ((s_axi.awvalid && s_axi.wvalid) ? W_ACCEPT : W_IDLE) :
                        r_wstate == W_ACCEPT ? W_RESP : s_axi.bready ? W_IDLE : W_RESP;
            if (w_wr) r_bresp <= w_bresp;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'd0;
        end else if (r_rstate == R_RESP) begin
            if (s_axi.rready) begin
                r_rstate  <= R_IDLE;
                r_arready <= 1'b1;
            end
        end else if (r_arready && s_axi.arvalid) begin
            r_rstate  <= R_RESP;
            r_arready <= 1'b0;
            r_rdata   <= w_rdata;
            r_rresp   <= w_rresp;
        end else begin
            r_arready <= 1'b1;
        end
    end

    assign s_axi.awready = w_wr;
    assign s_axi.wready  = w_wr;
    assign s_axi.bvalid  = r_wstate == W_RESP;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rstate == R_RESP;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
endmodule

// File: tb/tb_pkt_counter_bank.sv
// tb_pkt_counter_bank: randomized self-checking bench for pkt_counter_bank (three configurations).
// Ports: none; dut 0 = NCH 8/CW 48/SAT, dut 1 = NCH 2/CW 4/SAT, dut 2 = NCH 2/CW 4/wrap.
module tb_pkt_counter_bank;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    int          sel;
    logic [7:0]  awaddr, araddr;
    logic [31:0] wdata;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [7:0]  inc0;
    logic [1:0]  inc1, inc2;
    logic        stream_en, stream_inc;
    int          stream_cnt;
    int          errors, checks;

    pkt_counter_bank_if #(.AW(8)) if0 ();
    pkt_counter_bank_if #(.AW(8)) if1 ();
    pkt_counter_bank_if #(.AW(8)) if2 ();

    assign if0.awaddr = awaddr; assign if0.wdata = wdata; assign if0.araddr = araddr;
    assign if0.awprot = 3'd0; assign if0.arprot = 3'd0; assign if0.wstrb = 4'hF;
    assign if0.awvalid = awvalid && sel == 0; assign if0.wvalid = wvalid && sel == 0;
    assign if0.arvalid = arvalid && sel == 0; assign if0.bready = bready && sel == 0;
    assign if0.rready = rready && sel == 0;
    assign if1.awaddr = awaddr; assign if1.wdata = wdata; assign if1.araddr = araddr;
    assign if1.awprot = 3'd0; assign if1.arprot = 3'd0; assign if1.wstrb = 4'hF;
    assign if1.awvalid = awvalid && sel == 1; assign if1.wvalid = wvalid && sel == 1;
    assign if1.arvalid = arvalid && sel == 1; assign if1.bready = bready && sel == 1;
    assign if1.rready = rready && sel == 1;
    assign if2.awaddr = awaddr; assign if2.wdata = wdata; assign if2.araddr = araddr;
    assign if2.awprot = 3'd0; assign if2.arprot = 3'd0; assign if2.wstrb = 4'hF;
    assign if2.awvalid = awvalid && sel == 2; assign if2.wvalid = wvalid && sel == 2;
    assign if2.arvalid = arvalid && sel == 2; assign if2.bready = bready && sel == 2;
    assign if2.rready = rready && sel == 2;

    logic        awready_m, bvalid_m, arready_m, rvalid_m, wready_m;
    logic [1:0]  bresp_m, rresp_m;
    logic [31:0] rdata_m;
    assign awready_m = sel == 0 ? if0.awready : sel == 1 ? if1.awready : if2.awready;
    assign wready_m  = sel == 0 ? if0.wready  : sel == 1 ? if1.wready  : if2.wready;
    assign bvalid_m  = sel == 0 ? if0.bvalid  : sel == 1 ? if1.bvalid  : if2.bvalid;
    assign bresp_m   = sel == 0 ? if0.bresp   : sel == 1 ? if1.bresp   : if2.bresp;
    assign arready_m = sel == 0 ? if0.arready : sel == 1 ? if1.arready : if2.arready;
    assign rvalid_m  = sel == 0 ? if0.rvalid  : sel == 1 ? if1.rvalid  : if2.rvalid;
    assign rresp_m   = sel == 0 ? if0.rresp   : sel == 1 ? if1.rresp   : if2.rresp;
    assign rdata_m   = sel == 0 ? if0.rdata   : sel == 1 ? if1.rdata   : if2.rdata;

    logic [7:0] pkt0;
    assign pkt0 = inc0 | {7'd0, stream_inc};

    pkt_counter_bank #(.NCH(8), .CW(48), .SAT(1), .AW(8)) u0 (.clk(clk), .resetn(rstn), .pkt_inc(pkt0), .s_axi(if0));
    pkt_counter_bank #(.NCH(2), .CW(4), .SAT(1), .AW(8)) u1 (.clk(clk), .resetn(rstn), .pkt_inc(inc1), .s_axi(if1));
    pkt_counter_bank #(.NCH(2), .CW(4), .SAT(0), .AW(8)) u2 (.clk(clk), .resetn(rstn), .pkt_inc(inc2), .s_axi(if2));

    // reference model: live value, snapshot and sticky flag per dut/channel
    logic [63:0] m_cnt  [3][8];
    logic [63:0] m_snap [3][8];
    logic [7:0]  m_ovf  [3];

    function automatic logic [63:0] m_max(int d);
        return d == 0 ? 64'hFFFF_FFFF_FFFF : 64'hF;
    endfunction

    function automatic void m_inc(int d, int c);
        if (m_cnt[d][c] == m_max(d)) begin
            m_ovf[d][c] = 1'b1;
            m_cnt[d][c] = d == 2 ? 64'd0 : m_max(d);
        end else m_cnt[d][c] = m_cnt[d][c] + 64'd1;
    endfunction

    function automatic void m_ctrl(int d, logic [31:0] v);
        for (int c = 0; c < 8; c++) begin
            if (v[0]) m_snap[d][c] = m_cnt[d][c];
            if (v[1]) m_cnt[d][c] = 64'd0;
        end
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 3; d++) begin
            m_ovf[d] = 8'd0;
            for (int c = 0; c < 8; c++) begin
                m_cnt[d][c] = 64'd0;
                m_snap[d][c] = 64'd0;
            end
        end
    endfunction

    initial forever begin
        @(negedge clk);
        stream_inc = stream_en;
        if (stream_en) stream_cnt++;
    end

    task automatic drive_inc(int d, logic [7:0] vec, int n, bit rnd);
        logic [7:0] v;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            v = rnd ? 8'($urandom) : vec;
            v &= d == 0 ? 8'hFF : 8'h03;
            inc0 = d == 0 ? v : 8'd0;
            inc1 = d == 1 ? v[1:0] : 2'd0;
            inc2 = d == 2 ? v[1:0] : 2'd0;
            for (int c = 0; c < 8; c++) if (v[c]) m_inc(d, c);
        end
        @(negedge clk);
        inc0 = 8'd0; inc1 = 2'd0; inc2 = 2'd0;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] dt, input int stall, output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = a; wdata = dt; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready_m && n < 20);
        checks++;
        if (awready_m !== 1'b1 || wready_m !== 1'b1) begin
            errors++;
            $display("FAIL write_accept addr=%h: awready=%b wready=%b, need 1/1", a, awready_m, wready_m);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid_m && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bvalid_m !== 1'b1) begin
            errors++;
            $display("FAIL write_bvalid addr=%h: bvalid=%b, need 1", a, bvalid_m);
        end
        resp = bresp_m;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            checks++;
            if (bvalid_m !== 1'b1 || bresp_m !== resp) begin
                errors++;
                $display("FAIL write_hold cycle %0d: bvalid=%b bresp=%0d, need 1/%0d", k, bvalid_m, bresp_m, resp);
            end
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, input int stall, output logic [31:0] d, output logic [1:0] resp, output int lat);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready_m && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (arready_m !== 1'b1) begin
            errors++;
            $display("FAIL read_arready addr=%h: arready=%b, need 1", a, arready_m);
        end
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid_m && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (rvalid_m !== 1'b1) begin
            errors++;
            $display("FAIL read_rvalid addr=%h: rvalid=%b, need 1", a, rvalid_m);
        end
        d = rdata_m;
        resp = rresp_m;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            checks++;
            if (rvalid_m !== 1'b1 || rdata_m !== d || rresp_m !== resp) begin
                errors++;
                $display("FAIL read_hold cycle %0d: rvalid=%b rdata=%h rresp=%0d, need 1/%h/%0d", k, rvalid_m, rdata_m, rresp_m, d, resp);
            end
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d, id;
        logic [1:0] r;
        int lat;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        m_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({awready_m, wready_m, arready_m, bvalid_m, rvalid_m, bresp_m, rresp_m, rdata_m} !== 41'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: aw/w/ar/b/r=%b%b%b%b%b bresp=%0d rresp=%0d rdata=%h, need all 0",
                         s, awready_m, wready_m, arready_m, bvalid_m, rvalid_m, bresp_m, rresp_m, rdata_m);
            end
        end
        sel = 0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (arready_m !== 1'b0) begin
            errors++;
            $display("FAIL arready_at_release: arready=%b, need 0", arready_m);
        end
        @(negedge clk);
        checks++;
        if (arready_m !== 1'b1) begin
            errors++;
            $display("FAIL arready_after_release: arready=%b, need 1", arready_m);
        end
        for (int s = 0; s < 3; s++) begin
            sel = s;
            id = s == 0 ? 32'h5043_3008 : 32'h5043_0402;
            axi_read(8'h00, 0, d, r, lat);
            checks++;
            if (d !== id || r !== 2'd0 || lat != 1) begin
                errors++;
                $display("FAIL id_read dut%0d: rdata=%h rresp=%0d latency=%0d, need %h/0/1", s, d, r, lat, id);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] d;
        logic [1:0] r;
        int lat;
        sel = 0;
        drive_inc(0, 8'h08, 5, 0);
        axi_write(8'h04, 32'h1, 0, r);
        m_ctrl(0, 32'h1);
        checks++;
        if (r !== 2'd0) begin errors++; $display("FAIL snap_bresp: bresp=%0d, need 0", r); end
        axi_read(8'h28, 0, d, r, lat);
        checks++;
        if (d !== m_snap[0][3][63:32] || r !== 2'd0) begin
            errors++;
            $display("FAIL snap_hi_ch3: rdata=%h rresp=%0d, need %h/0", d, r, m_snap[0][3][63:32]);
        end
        axi_read(8'h2C, 0, d, r, lat);
        checks++;
        if (d !== m_snap[0][3][31:0] || d !== 32'd5) begin
            errors++;
            $display("FAIL snap_lo_ch3: rdata=%h, need %h", d, m_snap[0][3][31:0]);
        end
        drive_inc(0, 8'h08, 3, 0);
        axi_read(8'h2C, 0, d, r, lat);
        checks++;
        if (d !== m_snap[0][3][31:0]) begin
            errors++;
            $display("FAIL snap_frozen_ch3: rdata=%h, need %h", d, m_snap[0][3][31:0]);
        end
        drive_inc(0, 8'h00, 40, 1);
        axi_write(8'h04, 32'h1, 0, r);
        m_ctrl(0, 32'h1);
        for (int c = 0; c < 8; c++) begin
            axi_read(8'(16 + 8 * c), 0, d, r, lat);
            checks++;
            if (d !== m_snap[0][c][63:32]) begin
                errors++;
                $display("FAIL rand_snap_hi ch%0d: rdata=%h, need %h", c, d, m_snap[0][c][63:32]);
            end
            axi_read(8'(20 + 8 * c), 0, d, r, lat);
            checks++;
            if (d !== m_snap[0][c][31:0]) begin
                errors++;
                $display("FAIL rand_snap_lo ch%0d: rdata=%h, need %h", c, d, m_snap[0][c][31:0]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        logic [1:0] r;
        int lat;
        for (int s = 1; s < 3; s++) begin
            sel = s;
            drive_inc(s, 8'h01, 20, 0);
            axi_write(8'h04, 32'h1, 0, r);
            m_ctrl(s, 32'h1);
            axi_read(8'h14, 0, d, r, lat);
            checks++;
            if (d !== m_snap[s][0][31:0] || d !== (s == 1 ? 32'hF : 32'h4)) begin
                errors++;
                $display("FAIL cw4_lo dut%0d: rdata=%h, need %h", s, d, m_snap[s][0][31:0]);
            end
            axi_read(8'h08, 0, d, r, lat);
            checks++;
            if (d !== 32'(m_ovf[s]) || d !== 32'h1) begin
                errors++;
                $display("FAIL cw4_ovf dut%0d: rdata=%h, need %h", s, d, 32'(m_ovf[s]));
            end
        end
        sel = 1;
        axi_write(8'h08, 32'h1, 0, r);
        m_ovf[1] &= 8'hFE;
        checks++;
        if (r !== 2'd0) begin errors++; $display("FAIL ovf_w1c_bresp: bresp=%0d, need 0", r); end
        axi_read(8'h08, 0, d, r, lat);
        checks++;
        if (d !== 32'(m_ovf[1])) begin
            errors++;
            $display("FAIL ovf_w1c: rdata=%h, need %h", d, 32'(m_ovf[1]));
        end
        sel = 2;
        drive_inc(2, 8'h00, 30, 1);
        axi_write(8'h04, 32'h1, 0, r);
        m_ctrl(2, 32'h1);
        for (int c = 0; c < 2; c++) begin
            axi_read(8'(20 + 8 * c), 0, d, r, lat);
            checks++;
            if (d !== m_snap[2][c][31:0]) begin
                errors++;
                $display("FAIL wrap_rand_lo ch%0d: rdata=%h, need %h", c, d, m_snap[2][c][31:0]);
            end
        end
        axi_read(8'h08, 0, d, r, lat);
        checks++;
        if (d !== 32'(m_ovf[2])) begin
            errors++;
            $display("FAIL wrap_rand_ovf: rdata=%h, need %h", d, 32'(m_ovf[2]));
        end
    endtask

    task automatic test_read_clear();
        logic [31:0] d;
        logic [63:0] s1, s2;
        logic [1:0] r;
        int lat;
        sel = 0;
        axi_write(8'h04, 32'h2, 0, r);
        m_ctrl(0, 32'h2);
        stream_cnt = 0;
        @(posedge clk);
        stream_en = 1'b1;
        repeat (7) @(negedge clk);
        axi_write(8'h04, 32'h3, 0, r);
        m_ctrl(0, 32'h3);
        axi_read(8'h10, 0, d, r, lat);
        s1[63:32] = d;
        axi_read(8'h14, 0, d, r, lat);
        s1[31:0] = d;
        repeat (5) @(negedge clk);
        @(posedge clk);
        stream_en = 1'b0;
        @(negedge clk);
        axi_write(8'h04, 32'h1, 0, r);
        axi_read(8'h10, 0, d, r, lat);
        s2[63:32] = d;
        axi_read(8'h14, 0, d, r, lat);
        s2[31:0] = d;
        checks++;
        if (s1 + s2 !== 64'(stream_cnt - 1)) begin
            errors++;
            $display("FAIL read_and_clear: snap=%0d later=%0d sum=%0d, need %0d", s1, s2, s1 + s2, stream_cnt - 1);
        end
        axi_read(8'h1C, 0, d, r, lat);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL clear_other_ch1: rdata=%h, need 0", d);
        end
        axi_write(8'h04, 32'h2, 0, r);
        m_ctrl(0, 32'h2);
    endtask

    task automatic test_errors();
        logic [31:0] d, old;
        logic [1:0] r, rr;
        int lat;
        logic [7:0] wa [5] = '{8'h10, 8'h00, 8'h0C, 8'hFC, 8'h08};
        logic [1:0] we [5] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        sel = 0;
        for (int k = 0; k < 5; k++) begin
            axi_write(wa[k], k == 4 ? 32'h0 : 32'h3, k == 4 ? 5 : 0, r);
            checks++;
            if (r !== we[k]) begin
                errors++;
                $display("FAIL bresp_addr_%h: bresp=%0d, need %0d", wa[k], r, we[k]);
            end
        end
        axi_read(8'hFC, 5, d, r, lat);
        checks++;
        if (d !== 32'd0 || r !== 2'd3) begin
            errors++;
            $display("FAIL read_decerr: rdata=%h rresp=%0d, need 0/3", d, r);
        end
        axi_read(8'h0C, 0, d, r, lat);
        checks++;
        if (d !== 32'd0 || r !== 2'd0) begin
            errors++;
            $display("FAIL read_reserved: rdata=%h rresp=%0d, need 0/0", d, r);
        end
        axi_read(8'h04, 0, d, r, lat);
        checks++;
        if (d !== 32'd0 || r !== 2'd0) begin
            errors++;
            $display("FAIL read_ctrl: rdata=%h rresp=%0d, need 0/0", d, r);
        end
        sel = 1;
        axi_write(8'h20, 32'h1, 0, r);
        checks++;
        if (r !== 2'd3) begin errors++; $display("FAIL bresp_small_map_w8: bresp=%0d, need 3", r); end
        axi_write(8'h1C, 32'h1, 0, r);
        checks++;
        if (r !== 2'd2) begin errors++; $display("FAIL bresp_small_map_w7: bresp=%0d, need 2", r); end
        axi_read(8'h20, 0, d, r, lat);
        checks++;
        if (r !== 2'd3 || d !== 32'd0) begin
            errors++;
            $display("FAIL rresp_small_map_w8: rdata=%h rresp=%0d, need 0/3", d, r);
        end
        sel = 0;
        drive_inc(0, 8'h08, 4, 0);
        old = m_snap[0][3][31:0];
        fork
            axi_read(8'h2C, 8, d, r, lat);
            begin
                @(negedge clk);
                axi_write(8'h04, 32'h1, 0, rr);
            end
        join
        m_ctrl(0, 32'h1);
        checks++;
        if (d !== old) begin
            errors++;
            $display("FAIL held_rdata_vs_snapshot: rdata=%h, need %h", d, old);
        end
        axi_read(8'h2C, 0, d, r, lat);
        checks++;
        if (d !== m_snap[0][3][31:0]) begin
            errors++;
            $display("FAIL snap_after_pending_read: rdata=%h, need %h", d, m_snap[0][3][31:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0] r;
        int lat, n;
        sel = 0;
        drive_inc(0, 8'h08, 3, 0);
        @(negedge clk);
        awaddr = 8'h04; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready_m && n < 20);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid_m !== 1'b1) begin errors++; $display("FAIL mid_bvalid_before: bvalid=%b, need 1", bvalid_m); end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (bvalid_m !== 1'b0) begin errors++; $display("FAIL mid_bvalid_async: bvalid=%b, need 0", bvalid_m); end
        m_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bvalid_m !== 1'b0) begin errors++; $display("FAIL mid_no_response: bvalid=%b, need 0", bvalid_m); end
        sel = 2;
        axi_read(8'h08, 0, d, r, lat);
        checks++;
        if (d !== 32'(m_ovf[2])) begin errors++; $display("FAIL mid_ovf_cleared: rdata=%h, need %h", d, 32'(m_ovf[2])); end
        sel = 0;
        axi_write(8'h04, 32'h1, 0, r);
        m_ctrl(0, 32'h1);
        checks++;
        if (r !== 2'd0) begin errors++; $display("FAIL mid_next_write: bresp=%0d, need 0", r); end
        axi_read(8'h2C, 0, d, r, lat);
        checks++;
        if (d !== m_snap[0][3][31:0]) begin errors++; $display("FAIL mid_counter_cleared: rdata=%h, need %h", d, m_snap[0][3][31:0]); end
    endtask

    initial begin
        errors = 0; checks = 0; sel = 0;
        awaddr = '0; araddr = '0; wdata = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        inc0 = '0; inc1 = '0; inc2 = '0;
        stream_en = 1'b0; stream_inc = 1'b0; stream_cnt = 0;
        test_reset();
        test_snapshot();
        test_saturation();
        test_read_clear();
        test_errors();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
